fcmp_seq: RTL

Sequencing front-end for the single-precision `fle` comparator in the FPU. It accepts FEQ/FLT/FLE requests over a valid/ready handshake and drives the comparator's `x1`/`x2` inputs, one or two passes per request. It combines the registered comparator result with NaN detection and returns a 0/1 result, an invalid flag and a tag over a valid/ready output to writeback.

---
 rtl/fcmp_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fcmp_seq.sv
// Sequencer around the registered single-precision fle comparator: runs one or
// two passes per FEQ/FLT/FLE request and returns a 0/1 result, nv flag and tag.
module fcmp_seq #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      cmp_x1,
   output logic [31:0]      cmp_x2,
   input  logic             cmp_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_nv,
   output logic [TAG_W-1:0] out_tag
);
   typedef enum logic [1:0] {S_IDLE, S_A, S_B, S_RES} state_t;
   localparam logic [1:0] OP_FLE = 2'd0, OP_FLT = 2'd1, OP_FEQ = 2'd2;

   state_t             state_q, state_d;
   logic [1:0]         op_q;
   logic [31:0]        a_q, b_q;
   logic [TAG_W-1:0]   tag_q;
   logic               ya;
   logic               out_wr, accept, swap;
   logic               nan_a, nan_b, snan_a, snan_b, res_d, nv_d;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      out_wr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_A;
         end
         S_A:   state_d = (op_q == OP_FEQ) ? S_B : S_RES;
         S_B:   state_d = S_RES;
         S_RES: begin
            if (!out_valid || out_ready) begin
               out_wr   = 1'b1;
               in_ready = 1'b1;
               state_d  = in_valid ? S_A : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   // Outside pass A the final-pass pair is held, keeping cmp_y stable in RES
   // and leaving the last pair on the bus in IDLE.
   always_comb begin
      swap = 1'b0;
      case (state_q)
         S_A:     swap = (op_q == OP_FLT);
         S_B:     swap = 1'b1;
         default: swap = (op_q == OP_FLT) || (op_q == OP_FEQ);
      endcase
   end
   assign cmp_x1 = swap ? b_q : a_q;
   assign cmp_x2 = swap ? a_q : b_q;

   assign nan_a  = (&a_q[30:23]) && (|a_q[22:0]);
   assign nan_b  = (&b_q[30:23]) && (|b_q[22:0]);
   assign snan_a = nan_a && !a_q[22];
   assign snan_b = nan_b && !b_q[22];

   always_comb begin
      res_d = 1'b0;
      nv_d  = 1'b0;
      case (op_q)
         OP_FLE: begin res_d = cmp_y;       nv_d = nan_a || nan_b;   end
         OP_FLT: begin res_d = !cmp_y;      nv_d = nan_a || nan_b;   end
         OP_FEQ: begin res_d = ya && cmp_y; nv_d = snan_a || snan_b; end
         default: ;
      endcase
      if (nan_a || nan_b) res_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         op_q    <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         tag_q   <= '0;
         ya      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= in_op;
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
         end
         if (state_q == S_B) ya <= cmp_y;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid  <= 1'b0;
         out_result <= 32'd0;
         out_nv     <= 1'b0;
         out_tag    <= '0;
      end else if (out_wr) begin
         out_valid  <= 1'b1;
         out_result <= {31'd0, res_d};
         out_nv     <= nv_d;
         out_tag    <= tag_q;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end
endmodule
